vga_pixel_arbiter: RTL and testbench

//  Shares the single VGA adapter pixel-write port (x, y, color, writeEn) between two

---
 rtl/vga_pixel_arbiter.sv | 158 +++++++++++++++
 tb/tb_vga_pixel_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel-write port between two drawing
// engines, with a built-in raster clear sequencer. All adapter-facing outputs are registered.
module vga_pixel_arbiter #(
  parameter int unsigned WIDTH       = 160,
  parameter int unsigned HEIGHT      = 120,
  parameter logic [8:0]  CLEAR_COLOR = 9'd0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0_valid,
  input  logic [7:0] req0_x,
  input  logic [6:0] req0_y,
  input  logic [8:0] req0_color,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_x,
  input  logic [6:0] req1_y,
  input  logic [8:0] req1_color,
  output logic       req1_ready,
  input  logic       clear_start,
  output logic       busy,
  output logic       clear_done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [8:0] color,
  output logic       writeEn
);

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned C_W = 9;
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e          state_q, state_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [C_W-1:0]  color_q, color_d;
  logic            we_q, we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [X_W-1:0]  cx_q, cx_d;
  logic [Y_W-1:0]  cy_q, cy_d;
  logic            last_grant_q, last_grant_d;

  logic gnt0, gnt1, in_range0, in_range1, last_pix;

  // Round-robin pick: when both request, the one not granted last time wins
  assign gnt0      = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1      = req1_valid & (~req0_valid | ~last_grant_q);
  assign in_range0 = (32'(req0_x) < WIDTH) && (32'(req0_y) < HEIGHT);
  assign in_range1 = (32'(req1_x) < WIDTH) && (32'(req1_y) < HEIGHT);
  assign last_pix  = (cx_q == X_LAST) && (cy_q == Y_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clear_start) state_d = S_CLEAR;
      S_CLEAR: if (last_pix)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;
    we_d         = 1'b0;
    done_d       = 1'b0;
    cx_d         = cx_q;
    cy_d         = cy_q;
    last_grant_d = last_grant_q;
    busy_d       = (state_d == S_CLEAR);
    case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          cx_d = '0;
          cy_d = '0;
        end else if (gnt0) begin
          req0_ready   = 1'b1;
          last_grant_d = 1'b0;
          if (in_range0) begin
            x_d     = req0_x;
            y_d     = req0_y;
            color_d = req0_color;
            we_d    = 1'b1;
          end
        end else if (gnt1) begin
          req1_ready   = 1'b1;
          last_grant_d = 1'b1;
          if (in_range1) begin
            x_d     = req1_x;
            y_d     = req1_y;
            color_d = req1_color;
            we_d    = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        // Raster walk: x fastest, y steps on x wrap
        x_d     = cx_q;
        y_d     = cy_q;
        color_d = CLEAR_COLOR;
        we_d    = 1'b1;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            cy_d   = '0;
            done_d = 1'b1;
          end else begin
            cy_d = cy_q + Y_W'(1);
          end
        end else begin
          cx_d = cx_q + X_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign x          = x_q;
  assign y          = y_q;
  assign color      = color_q;
  assign writeEn    = we_q;
  assign busy       = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// Directed bench for vga_pixel_arbiter: a per-cycle reference model compared on every
// falling edge, plus literal checks that pin the model at the interesting moments.
module tb_vga_pixel_arbiter;

  localparam int W = 160;
  localparam int H = 120;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req0_valid, req1_valid, clear_start;
  logic [7:0] req0_x, req1_x;
  logic [6:0] req0_y, req1_y;
  logic [8:0] req0_color, req1_color;
  logic       req0_ready, req1_ready, busy, clear_done, writeEn;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] color;

  int vectors = 0;
  int errors  = 0;
  bit armed   = 1'b0;

  vga_pixel_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
    .req0_color(req0_color), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
    .req1_color(req1_color), .req1_ready(req1_ready),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .x(x), .y(y), .color(color), .writeEn(writeEn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear progress is a linear pixel index, outputs derive from it
  bit       m_clear = 1'b0;
  int       m_n     = 0;
  bit       m_lg    = 1'b1;
  int       e_x = 0, e_y = 0, e_c = 0;
  bit       e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  always @(negedge clk) begin
    bit r0, r1, idle;
    if (armed) begin
      if (!resetn) begin
        m_clear = 1'b0; m_n = 0; m_lg = 1'b1;
        e_x = 0; e_y = 0; e_c = 0; e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end
      chk("m_x", 32'(x), 32'(e_x));
      chk("m_y", 32'(y), 32'(e_y));
      chk("m_color", 32'(color), 32'(e_c));
      chk("m_we", 32'(writeEn), 32'(e_we));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_done", 32'(clear_done), 32'(e_done));
      idle = !m_clear;
      r0 = idle && !clear_start && req0_valid && (!req1_valid || m_lg);
      r1 = idle && !clear_start && req1_valid && (!req0_valid || !m_lg);
      chk("m_ready0", 32'(req0_ready), 32'(r0));
      chk("m_ready1", 32'(req1_ready), 32'(r1));
      if (resetn) begin
        e_we = 1'b0;
        e_done = 1'b0;
        if (m_clear) begin
          e_x = m_n % W; e_y = m_n / W; e_c = 0; e_we = 1'b1;
          m_n++;
          if (m_n == W * H) begin
            m_clear = 1'b0; e_done = 1'b1;
          end
          e_busy = m_clear;
        end else if (clear_start) begin
          m_clear = 1'b1; m_n = 0; e_busy = 1'b1;
        end else if (r0) begin
          m_lg = 1'b0;
          if (int'(req0_x) < W && int'(req0_y) < H) begin
            e_x = int'(req0_x); e_y = int'(req0_y); e_c = int'(req0_color); e_we = 1'b1;
          end
        end else if (r1) begin
          m_lg = 1'b1;
          if (int'(req1_x) < W && int'(req1_y) < H) begin
            e_x = int'(req1_x); e_y = int'(req1_y); e_c = int'(req1_color); e_we = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, nw, nd, extra;
    bit seen;
    bit exp_g0 [4];
    exp_g0 = '{1'b1, 1'b0, 1'b1, 1'b0};

    resetn = 1'b0; clear_start = 1'b0;
    req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_color = '0;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_color = '0;
    tick();
    armed = 1'b1;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_we", 32'(writeEn), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(clear_done), 32'd0);
    tick();
    resetn = 1'b1;

    // 1: single requester, one-cycle latency
    req0_valid = 1'b1; req0_x = 8'd10; req0_y = 7'd20; req0_color = 9'h1FF;
    #1;
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    chk("t1_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("t1_x", 32'(x), 32'd10);
    chk("t1_y", 32'(y), 32'd20);
    chk("t1_color", 32'(color), 32'h1FF);
    chk("t1_we", 32'(writeEn), 32'd1);

    // 2: fresh reset, both valid -> 0,1,0,1
    resetn = 1'b0; tick(); resetn = 1'b1;
    req0_valid = 1'b1; req0_x = 8'd1; req0_y = 7'd2; req0_color = 9'd3;
    req1_valid = 1'b1; req1_x = 8'd4; req1_y = 7'd5; req1_color = 9'd6;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_grant0", 32'(req0_ready), 32'(exp_g0[k]));
      chk("t2_grant1", 32'(req1_ready), 32'(!exp_g0[k]));
      tick();
      chk("t2_x", 32'(x), exp_g0[k] ? 32'd1 : 32'd4);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 3: out-of-range pixel accepted and dropped
    req1_valid = 1'b1; req1_x = 8'd160; req1_y = 7'd5; req1_color = 9'h007;
    #1;
    chk("t3_ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    chk("t3_we", 32'(writeEn), 32'd0);
    chk("t3_x", 32'(x), 32'd4);
    chk("t3_color", 32'(color), 32'd6);
    req0_valid = 1'b1; req0_x = 8'd3; req0_y = 7'd120; req0_color = 9'd1;
    tick();
    req0_valid = 1'b0;
    chk("t3_ywe", 32'(writeEn), 32'd0);

    // 4: clear with req0 waiting
    req0_valid = 1'b1; req0_x = 8'd7; req0_y = 7'd8; req0_color = 9'h0AA;
    clear_start = 1'b1;
    #1;
    chk("t4_ready0_start", 32'(req0_ready), 32'd0);
    n0 = 1; nw = 0; nd = 0; seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      clear_start = 1'b0;
      #1;
      if (writeEn) nw++;
      if (clear_done) nd++;
      if (req0_ready) begin seen = 1'b1; break; end
      n0++;
    end
    chk("t4_seen", 32'(seen), 32'd1);
    chk("t4_blocked", 32'(n0), 32'd19201);
    chk("t4_writes", 32'(nw), 32'd19200);
    chk("t4_dones", 32'(nd), 32'd1);
    chk("t4_last_x", 32'(x), 32'd159);
    chk("t4_last_y", 32'(y), 32'd119);
    chk("t4_last_c", 32'(color), 32'd0);
    chk("t4_done", 32'(clear_done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("t4_after_x", 32'(x), 32'd7);
    chk("t4_after_c", 32'(color), 32'h0AA);
    chk("t4_after_we", 32'(writeEn), 32'd1);

    // 5: extra clear_start pulses mid-clear are ignored
    clear_start = 1'b1;
    nw = 0; nd = 0; seen = 1'b0; extra = 0;
    for (int i = 1; i < 20010; i++) begin
      tick();
      clear_start = (i == 100 || i == 5000);
      #1;
      if (writeEn) nw++;
      if (clear_done) begin nd++; seen = 1'b1; end
      if (seen) extra++;
      if (extra == 4) break;
    end
    clear_start = 1'b0;
    chk("t5_seen", 32'(seen), 32'd1);
    chk("t5_writes", 32'(nw), 32'd19200);
    chk("t5_dones", 32'(nd), 32'd1);

    // 6: reset aborts a clear
    clear_start = 1'b1;
    nw = 0; nd = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      clear_start = 1'b0;
      #1;
      if (writeEn) nw++;
      if (nw == 500) break;
    end
    chk("t6_reached", 32'(nw), 32'd500);
    #1;
    resetn = 1'b0;
    #1;
    chk("t6_x", 32'(x), 32'd0);
    chk("t6_y", 32'(y), 32'd0);
    chk("t6_we", 32'(writeEn), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    tick(); tick();
    resetn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (clear_done) nd++;
    end
    chk("t6_nodone", 32'(nd), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    req0_valid = 1'b1; req0_x = 8'd50; req0_y = 7'd60; req0_color = 9'd70;
    req1_valid = 1'b1; req1_x = 8'd51; req1_y = 7'd61; req1_color = 9'd71;
    #1;
    chk("t6_ready0", 32'(req0_ready), 32'd1);
    chk("t6_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t6_x_out", 32'(x), 32'd50);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
